// File: rtl/pu_matvec_stream.sv
// LANES-wide signed multiply-accumulate slice of y = M*x with a per-job column count.
// Operands stream in over valid/ready; the accumulated row slice leaves over valid/ready.
module pu_matvec_stream #(
    parameter int WIDTH_OP1 = 16,
    parameter int WIDTH_OP2 = 16,
    parameter int WIDTH_OUT = 32,
    parameter int LANES     = 8,
    parameter int MAX_COL   = 16,
    parameter int SAT       = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           START,
    input  logic [$clog2(MAX_COL+1)-1:0]   NUM_COL,
    input  logic                           A_VALID,
    output logic                           A_READY,
    input  logic [WIDTH_OP1-1:0]           A,
    input  logic [WIDTH_OP2*LANES-1:0]     B,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [WIDTH_OUT*LANES-1:0]     OUT,
    output logic [LANES-1:0]               OVF,
    output logic                           BUSY,
    output logic                           DONE
);

    localparam int PW = WIDTH_OP1 + WIDTH_OP2;
    localparam int CW = $clog2(MAX_COL + 1);
    localparam logic signed [WIDTH_OUT-1:0] ACC_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_OUT-1:0] ACC_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_FLUSH  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    // Handshakes: a beat moves when A_VALID & A_READY at a rising edge, a result
    // when OUT_VALID & OUT_READY; OUT/OVF hold steady while OUT_VALID waits.
    state_t state_q, state_d;
    logic [CW-1:0] ncol_q, ncol_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] ncol_sel;
    logic a_ready_q, a_ready_d;
    logic out_valid_q, out_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic p_valid_q, p_valid_d;
    logic signed [PW-1:0] prod_q [LANES];
    logic signed [PW-1:0] prod_d [LANES];
    logic signed [WIDTH_OUT-1:0] acc_q [LANES];
    logic signed [WIDTH_OUT-1:0] acc_d [LANES];
    logic [LANES-1:0] ovf_q, ovf_d;

    logic signed [WIDTH_OUT-1:0] p_ext [LANES];
    logic signed [WIDTH_OUT-1:0] sum [LANES];
    logic [LANES-1:0] add_ovf;

    // Signed overflow: both addends share a sign that the sum does not.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            p_ext[l]   = WIDTH_OUT'(prod_q[l]);
            sum[l]     = acc_q[l] + p_ext[l];
            add_ovf[l] = (acc_q[l][WIDTH_OUT-1] == p_ext[l][WIDTH_OUT-1]) &&
                         (sum[l][WIDTH_OUT-1] != acc_q[l][WIDTH_OUT-1]);
        end
    end

    assign cnt_inc  = cnt_q + CW'(1);
    assign ncol_sel = (NUM_COL > CW'(MAX_COL)) ? CW'(MAX_COL) : NUM_COL;

    always_comb begin
        state_d     = state_q;
        ncol_d      = ncol_q;
        cnt_d       = cnt_q;
        a_ready_d   = a_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        p_valid_d   = 1'b0;
        prod_d      = prod_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;

        if (p_valid_q) begin
            for (int l = 0; l < LANES; l++) begin
                if (add_ovf[l] && (SAT != 0)) begin
                    acc_d[l] = acc_q[l][WIDTH_OUT-1] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_d[l] = sum[l];
                end
                ovf_d[l] = ovf_q[l] | add_ovf[l];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ncol_d = ncol_sel;
                    cnt_d  = '0;
                    ovf_d  = '0;
                    busy_d = 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = '0;
                    end
                    if (ncol_sel != '0) begin
                        state_d   = S_ACC;
                        a_ready_d = 1'b1;
                    end else begin
                        state_d     = S_RESULT;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (A_VALID && a_ready_q) begin
                    for (int l = 0; l < LANES; l++) begin
                        prod_d[l] = PW'($signed(A)) * PW'($signed(B[l*WIDTH_OP2 +: WIDTH_OP2]));
                    end
                    p_valid_d = 1'b1;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == ncol_q) begin
                        state_d   = S_FLUSH;
                        a_ready_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                state_d     = S_RESULT;
                out_valid_d = 1'b1;
            end
            S_RESULT: begin
                if (OUT_READY) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ncol_q      <= '0;
            cnt_q       <= '0;
            a_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            p_valid_q   <= 1'b0;
            ovf_q       <= '0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
                acc_q[l]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ncol_q      <= ncol_d;
            cnt_q       <= cnt_d;
            a_ready_q   <= a_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            p_valid_q   <= p_valid_d;
            ovf_q       <= ovf_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign OUT[g*WIDTH_OUT +: WIDTH_OUT] = acc_q[g];
    end

    assign A_READY   = a_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OVF       = ovf_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
